// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter.
//   - state_t      : write-port FSM states (IDLE / WRITE)
//   - REG_ADDR_W   : register-file address width
//   - REQ_DBG/REQ_WB : bit positions of each requester in grant/eligibility vectors
//   - PRIO_DBG/PRIO_WB : encodings of the round-robin priority bit
package regfile_wr_arbiter_pkg;

  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  localparam int REQ_DBG = 0;
  localparam int REQ_WB  = 1;

  localparam logic PRIO_DBG = 1'b0;
  localparam logic PRIO_WB  = 1'b1;

endpackage

// File: rtl/regfile_wr_arbiter_rr_arb2.sv
// Two-way round-robin grant logic.
// Ports:
//   elig      [1:0] in  : eligibility per requester (REQ_DBG / REQ_WB)
//   prio            in  : current priority bit (PRIO_DBG / PRIO_WB)
//   grant     [1:0] out : one-hot grant (all zero when nobody is eligible)
//   prio_next       out : priority bit to register for the next cycle
// The priority only moves on contested cycles; a lone requester is granted
// without disturbing the fairness pointer.
module rr_arb2
  import regfile_wr_arbiter_pkg::*;
(
  input  logic [1:0] elig,
  input  logic       prio,
  output logic [1:0] grant,
  output logic       prio_next
);

  always_comb begin
    grant     = 2'b00;
    prio_next = prio;
    if (&elig) begin
      if (prio == PRIO_DBG) begin
        grant[REQ_DBG] = 1'b1;
        prio_next      = PRIO_WB;
      end else begin
        grant[REQ_WB]  = 1'b1;
        prio_next      = PRIO_DBG;
      end
    end else begin
      grant = elig;
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter between the writeback stage (WB) and the
// debug unit (DBG). One write per cycle is granted; the granted address/data
// is registered and presented with an active-low strobe one cycle later.
// Ports:
//   clk, resetn_i                       : clock, async active-low reset
//   WB_ARB_give_i/rd_i/d_i, ARB_WB_get_o : WB request / acceptance
//   DBG_ARB_give_i/rd_i/d_i, ARB_DBG_get_o : debug request / acceptance
//   dbg_halt_i                          : blocks WB while the core is halted
//   REG_rd_o, REG_d_o, REG_access_o     : register-file write port (strobe active-low)
module regfile_wr_arbiter
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int BITSIZE = 32
) (
  input  logic                  clk,
  input  logic                  resetn_i,
  input  logic                  WB_ARB_give_i,
  input  logic [REG_ADDR_W-1:0] WB_ARB_rd_i,
  input  logic [BITSIZE-1:0]    WB_ARB_d_i,
  output logic                  ARB_WB_get_o,
  input  logic                  DBG_ARB_give_i,
  input  logic [REG_ADDR_W-1:0] DBG_ARB_rd_i,
  input  logic [BITSIZE-1:0]    DBG_ARB_d_i,
  output logic                  ARB_DBG_get_o,
  input  logic                  dbg_halt_i,
  output logic [REG_ADDR_W-1:0] REG_rd_o,
  output logic [BITSIZE-1:0]    REG_d_o,
  output logic                  REG_access_o
);

  logic [1:0]            elig_p0;
  logic [1:0]            grant_p0;
  logic                  prio_q;
  logic                  prio_next;
  reg_addr_t             sel_rd_p0;
  logic [BITSIZE-1:0]    sel_d_p0;
  logic                  write_go_p0;

  state_t                state_q;
  state_t                state_d;
  reg_addr_t             rd_p1;
  logic [BITSIZE-1:0]    d_p1;

  // ---- Stage p0: eligibility, grant and operand selection ----
  assign elig_p0[REQ_DBG] = DBG_ARB_give_i;
  assign elig_p0[REQ_WB]  = WB_ARB_give_i & ~dbg_halt_i;

  rr_arb2 u_rr_arb2 (
    .elig      (elig_p0),
    .prio      (prio_q),
    .grant     (grant_p0),
    .prio_next (prio_next)
  );

  // Gating with resetn_i keeps the acknowledges low during reset even if
  // a requester is already presenting.
  assign ARB_WB_get_o  = grant_p0[REQ_WB]  & resetn_i;
  assign ARB_DBG_get_o = grant_p0[REQ_DBG] & resetn_i;

  assign sel_rd_p0 = grant_p0[REQ_WB] ? WB_ARB_rd_i : DBG_ARB_rd_i;
  assign sel_d_p0  = grant_p0[REQ_WB] ? WB_ARB_d_i  : DBG_ARB_d_i;

  // Register 0 is hard-wired: the request is acknowledged but never written,
  // and the output address/data keep their previous values.
  assign write_go_p0 = (|grant_p0) && (sel_rd_p0 != '0);

  always_comb begin
    state_d = IDLE;
    if (write_go_p0) begin
      state_d = WRITE;
    end
  end

  // ---- Stage p1: registered write port ----
  always_ff @(posedge clk or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q <= IDLE;
      prio_q  <= PRIO_DBG;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_next;
    end
  end

  always_ff @(posedge clk or negedge resetn_i) begin
    if (!resetn_i) begin
      rd_p1 <= '0;
      d_p1  <= '0;
    end else if (write_go_p0) begin
      rd_p1 <= sel_rd_p0;
      d_p1  <= sel_d_p0;
    end
  end

  assign REG_rd_o     = rd_p1;
  assign REG_d_o      = d_p1;
  assign REG_access_o = (state_q != WRITE);

endmodule

// File: doc/regfile_wr_arbiter.md
REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 SHALL have parameter BITSIZE, default 32, register data width.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port resetn_i  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port WB_ARB_give_i  input  1  WB stage presents a write request.
REQ-005 SHALL have port WB_ARB_rd_i  input  5  WB destination register.
REQ-006 SHALL have port WB_ARB_d_i  input  BITSIZE  WB write data.
REQ-007 SHALL have port ARB_WB_get_o  output  1  WB request accepted this cycle.
REQ-008 SHALL have port DBG_ARB_give_i  input  1  debug unit presents a write request.
REQ-009 SHALL have port DBG_ARB_rd_i  input  5  debug destination register.
REQ-010 SHALL have port DBG_ARB_d_i  input  BITSIZE  debug write data.
REQ-011 SHALL have port ARB_DBG_get_o  output  1  debug request accepted this cycle.
REQ-012 SHALL have port dbg_halt_i  input  1  core halted; WB requests are blocked.
REQ-013 SHALL have port REG_rd_o  output  5  register file write address.
REQ-014 SHALL have port REG_d_o  output  BITSIZE  register file write data.
REQ-015 SHALL have port REG_access_o  output  1  register file write strobe, active-low.

Function
REQ-016 SHALL implement FSM states IDLE and WRITE; REG_access_o is low only in WRITE.
REQ-017 SHALL treat a requester as eligible when its give_i is high; WB is additionally ineligible while dbg_halt_i is high.
REQ-018 SHALL, every cycle in either state, grant at most one eligible requester; get_o to the granted requester is combinational and high for exactly that cycle.
REQ-019 SHALL, on a grant, register the granted rd/d into REG_rd_o/REG_d_o at the next rising edge and enter WRITE; one-cycle latency from grant to strobe.
REQ-020 SHALL, when no requester is eligible, go to IDLE at the next edge; REG_rd_o/REG_d_o hold their last values.
REQ-021 SHALL support back-to-back grants: WRITE->WRITE when a new grant occurs in the WRITE cycle; sustained throughput of one write per cycle.
REQ-022 SHALL resolve simultaneous eligible requests round-robin: a priority bit points to the requester not granted last; after reset it points to DBG.
REQ-023 SHALL update the priority bit only on a contested cycle (both eligible); an uncontested grant leaves it unchanged.
REQ-024 SHALL accept a request with rd = 0 (get_o high) but SHALL NOT strobe: the next state is IDLE unless another grant applies, and REG_access_o stays high.
REQ-025 SHALL never grant WB while dbg_halt_i is high, including when WB is the only requester; WB's give_i is held until halt clears.
REQ-026 SHALL require requesters to keep give/rd/d stable until get_o; the arbiter samples rd/d only in the grant cycle.

Reset
REQ-027 SHALL, while resetn_i is low, force state IDLE, REG_access_o = 1, REG_rd_o = 0, REG_d_o = 0, priority bit = DBG, both get_o = 0, asynchronously.
REQ-028 SHALL drop any write whose strobe is pending or in progress when reset asserts mid-operation; no strobe on the first edge after reset release.

Structure
REQ-029 SHALL place the FSM state enum and the register-address width constant (5) in the shared core package.
REQ-030 SHALL implement the two-way round-robin grant logic (eligibility in, one-hot grant and next priority out) as sub-module rr_arb2.

Verification
REQ-031 SHALL check: WB give rd=5 d=0xDEADBEEF alone -> ARB_WB_get_o high the same cycle; next cycle REG_access_o=0, REG_rd_o=5, REG_d_o=0xDEADBEEF.
REQ-032 SHALL check: WB rd=3 and DBG rd=4 both held from reset -> DBG granted first, WB next cycle; strobes in two consecutive cycles, rd 4 then 3.
REQ-033 SHALL check: dbg_halt_i=1, WB give rd=7 for 10 cycles -> no ARB_WB_get_o, REG_access_o stays 1; halt drops -> grant that cycle, strobe rd=7 the cycle after.
REQ-034 SHALL check: DBG give rd=0 d=0x1234 -> ARB_DBG_get_o pulses, REG_access_o stays 1, REG_rd_o/REG_d_o unchanged.
REQ-035 SHALL check: resetn_i low in the cycle after a WB grant rd=9 -> REG_access_o=1 immediately, no rd=9 strobe after release, all outputs at reset values.
REQ-036 SHALL check: 8 alternating contested cycles with both requesters held -> grants strictly alternate DBG, WB, DBG, ...; one strobe per cycle.
